multi_counter_game: RTL and testbench
=====================================

# multi_counter_game

Parametrised successor to the two-player up/down counter game. `NCH` independent wrap-around counters of `WIDTH` bits each feed one shared game engine. The engine tallies per-channel all-ones ("win") and all-zeros ("lose") hits and declares game over when any tally reaches `TARGET`. The block sits between the stimulus interface and the scoreboard, and replaces the single-counter/single-game pair.

## Interface
- `WIDTH`, 4: counter width; counters wrap modulo 2^WIDTH.
- `NCH`, 2: number of counter channels (≥1).
- `TARGET`, 15: tally value that ends a game (1 ≤ TARGET ≤ 255); tally width `TW = $clog2(TARGET+1)`.
- `clk`  in  1  clock; all state changes on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `init`  in  NCH  per-channel load strobe.
- `val`  in  NCH*WIDTH  per-channel load value; channel i occupies `[i*WIDTH +: WIDTH]`.
- `ctrl`  in  2*NCH  per-channel mode; channel i occupies `[2i +: 2]`. Modes: 00 = +1, 01 = +2, 10 = −1, 11 = −2.
- `count`  out  NCH*WIDTH  current counter values.
- `winner`  out  NCH  per-channel pulse: `count == 2^WIDTH−1`.
- `loser`  out  NCH  per-channel pulse: `count == 0`.
- `gameover`  out  1  one-cycle pulse marking the end of a game.
- `who`  out  2  result code: 01 = win, 10 = lose, 00 otherwise.
- `who_ch`  out  max(1,$clog2(NCH))  index of the deciding channel; 0 when `gameover` is 0.

## Operation
- Reset (async assert) sets every output, counter, tally and the FSM to 0 / PLAY. `loser` is 0 during reset even though `count` is 0.
- Counter channel i on each edge:
  - `init[i]` = 1: load `val[i]`. Load has priority over counting.
  - Otherwise: apply `ctrl[i]`, with the result taken modulo 2^WIDTH. For example, 1 with −2 gives 2^WIDTH−1.
- `winner[i]` and `loser[i]` are registered from the updated count, so they are coherent with `count` in the same cycle. Both are recomputed every edge. A counter parked at the all-ones value holds `winner[i]` high on every cycle it stays there.
- Tallies: one `wtally[i]` and one `ltally[i]` per channel, each TW bits.
  - In PLAY, a high `winner[i]` increments `wtally[i]`.
  - In PLAY, a high `loser[i]` increments `ltally[i]`.
  - Tallies saturate at TARGET.
- FSM states:
  - PLAY: normal tallying. If any updated tally equals TARGET, go to OVER. On the same edge, assert `gameover`, and drive `who` and `who_ch`.
  - OVER, exactly one cycle: all tallies clear to 0 and hits are ignored. Then go to PLAY. `gameover`, `who` and `who_ch` return to 0 on that edge.
- Arbitration when several tallies reach TARGET on the same edge:
  - The lowest channel index wins.
  - Within one channel, win beats lose.
- Counters run continuously in both states. Only the game engine pauses.

## Timing
- Edge k: the counter becomes all-ones and `winner[i]` rises.
- Edge k+1: `wtally[i]` increments. If the new value equals TARGET, `gameover` = 1 at k+1.
- Edge k+2: `gameover` = 0 and tallies = 0.
- Counter latency is one edge from `init`/`ctrl` to `count`. `winner`/`loser` have zero additional latency relative to `count`.
- Back-to-back games are possible. Minimum spacing between `gameover` pulses is TARGET+1 cycles.
- If `rst` asserts mid-OVER: outputs clear immediately (asynchronously), and the FSM resumes in PLAY after deassertion.

## Structure
- Package `mcg_pkg`:
  - `state_t` enum {PLAY, OVER}.
  - `who_t` constants `WHO_NONE` = 2'b00, `WHO_WIN` = 2'b01, `WHO_LOSE` = 2'b10.
- Sub-module `updown_ctr`, instantiated NCH times via generate. It contains:
  - parameter `WIDTH`;
  - ports `clk`, `rst`, `init`, `val`, `ctrl`, `count`, `winner`, `loser`.
- The top level holds the tallies, the arbiter and the FSM.

## Test plan
All scenarios use WIDTH=4, NCH=2, TARGET=15.
- Reset: hold `rst` high, then release; all outputs are 0. Drive ch0 `ctrl`=00 for one edge → `count[0]`=1 with `winner`=`loser`=0.
- Wrap: ch0 loaded with 1, then `ctrl`=11 for two edges → `count[0]` 15 (`winner[0]`=1), then 13. Then load 14 with `ctrl`=00 → 15, 0 (`loser[0]`=1).
- Win game: ch0 `init`=1, `val`=15 held for 15 edges → `gameover`=1, `who`=01, `who_ch`=0 exactly one cycle after the 15th `winner` pulse. Next edge: `gameover`=0 and tallies are 0.
- Simultaneous: both channels held at `val`=0 from the same edge → both `ltally` reach 15 together → `who`=10, `who_ch`=0. The ch1 tally is also cleared.
- OVER ignore: keep ch1 at 15 through the OVER cycle → the hit is not counted, and `wtally[1]` restarts from 0 on the following PLAY edge.
- Mid-OVER reset: assert `rst` during the `gameover` cycle → `gameover` drops without waiting for an edge. After release, a 15-hit sequence is needed again before the next `gameover`.

Source files
------------

// File: rtl/mcg_pkg.sv
// Shared types for the multi-channel counter game: engine states and result codes.
package mcg_pkg;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        WHO_NONE = 2'b00,
        WHO_WIN  = 2'b01,
        WHO_LOSE = 2'b10
    } who_t;

endpackage

// File: rtl/updown_ctr.sv
// Wrap-around up/down counter with load priority and registered all-ones/all-zeros flags.
module updown_ctr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [WIDTH-1:0] val,
    input  logic [1:0]       ctrl,
    output logic [WIDTH-1:0] count,
    output logic             winner,
    output logic             loser
);

    logic [WIDTH-1:0] nxt;

    always_comb begin
        nxt = count;
        if (init) begin
            nxt = val;
        end else begin
            unique case (ctrl)
                2'b00:   nxt = count + WIDTH'(1);
                2'b01:   nxt = count + WIDTH'(2);
                2'b10:   nxt = count - WIDTH'(1);
                default: nxt = count - WIDTH'(2);
            endcase
        end
    end

    // Flags are derived from the next value so they line up with count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            winner <= 1'b0;
            loser  <= 1'b0;
        end else begin
            count  <= nxt;
            winner <= (nxt == '1);
            loser  <= (nxt == '0);
        end
    end

endmodule

// File: rtl/multi_counter_game.sv
// NCH independent counters feeding one game engine that tallies win/lose hits per channel.
module multi_counter_game
    import mcg_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int NCH    = 2,
    parameter int TARGET = 15,
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       init,
    input  logic [NCH*WIDTH-1:0] val,
    input  logic [2*NCH-1:0]     ctrl,
    output logic [NCH*WIDTH-1:0] count,
    output logic [NCH-1:0]       winner,
    output logic [NCH-1:0]       loser,
    output logic                 gameover,
    output logic [1:0]           who,
    output logic [CW-1:0]        who_ch
);

    localparam int TW = $clog2(TARGET + 1);
    localparam logic [TW-1:0] TGT = TW'(TARGET);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        updown_ctr #(.WIDTH(WIDTH)) u_ctr (
            .clk    (clk),
            .rst    (rst),
            .init   (init[i]),
            .val    (val[i*WIDTH +: WIDTH]),
            .ctrl   (ctrl[2*i +: 2]),
            .count  (count[i*WIDTH +: WIDTH]),
            .winner (winner[i]),
            .loser  (loser[i])
        );
    end

    state_t          state;
    logic [TW-1:0]   wtally [NCH];
    logic [TW-1:0]   ltally [NCH];
    logic [TW-1:0]   wnext  [NCH];
    logic [TW-1:0]   lnext  [NCH];
    logic            hit;
    who_t            hit_who;
    logic [CW-1:0]   hit_ch;

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            wnext[i] = wtally[i];
            lnext[i] = ltally[i];
            if (winner[i] && wtally[i] != TGT) wnext[i] = wtally[i] + 1'b1;
            if (loser[i]  && ltally[i] != TGT) lnext[i] = ltally[i] + 1'b1;
        end
    end

    // First channel in index order claims the result; win is checked before lose.
    always_comb begin
        hit     = 1'b0;
        hit_who = WHO_NONE;
        hit_ch  = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!hit) begin
                if (wnext[i] == TGT) begin
                    hit     = 1'b1;
                    hit_who = WHO_WIN;
                    hit_ch  = CW'(i);
                end else if (lnext[i] == TGT) begin
                    hit     = 1'b1;
                    hit_who = WHO_LOSE;
                    hit_ch  = CW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= PLAY;
            gameover <= 1'b0;
            who      <= WHO_NONE;
            who_ch   <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                wtally[i] <= '0;
                ltally[i] <= '0;
            end
        end else begin
            unique case (state)
                PLAY: begin
                    for (int unsigned i = 0; i < NCH; i++) begin
                        wtally[i] <= wnext[i];
                        ltally[i] <= lnext[i];
                    end
                    gameover <= hit;
                    who      <= hit ? hit_who : WHO_NONE;
                    who_ch   <= hit ? hit_ch : '0;
                    state    <= hit ? OVER : PLAY;
                end
                default: begin
                    for (int unsigned i = 0; i < NCH; i++) begin
                        wtally[i] <= '0;
                        ltally[i] <= '0;
                    end
                    gameover <= 1'b0;
                    who      <= WHO_NONE;
                    who_ch   <= '0;
                    state    <= PLAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_counter_game.sv
// Directed bench for multi_counter_game with WIDTH=4, NCH=2, TARGET=15.
module tb_multi_counter_game;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] init = '0;
    logic [7:0] val = '0;
    logic [3:0] ctrl = '0;
    logic [7:0] count;
    logic [1:0] winner;
    logic [1:0] loser;
    logic       gameover;
    logic [1:0] who;
    logic [0:0] who_ch;

    int n_checks = 0;
    int n_fail   = 0;

    multi_counter_game #(.WIDTH(4), .NCH(2), .TARGET(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .init     (init),
        .val      (val),
        .ctrl     (ctrl),
        .count    (count),
        .winner   (winner),
        .loser    (loser),
        .gameover (gameover),
        .who      (who),
        .who_ch   (who_ch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic i, input logic [3:0] v, input logic [1:0] c);
        init[ch]       = i;
        val[ch*4 +: 4] = v;
        ctrl[ch*2 +: 2] = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int c0();
        return int'(count[3:0]);
    endfunction

    function automatic int c1();
        return int'(count[7:4]);
    endfunction

    initial begin
        // Reset state
        set_ch(0, 1'b0, 4'd0, 2'b00);
        set_ch(1, 1'b0, 4'd0, 2'b00);
        do_reset();
        check("rst_count", int'(count), 0);
        check("rst_winner", int'(winner), 0);
        check("rst_loser", int'(loser), 0);
        check("rst_gameover", int'(gameover), 0);
        check("rst_who", int'(who), 0);
        check("rst_who_ch", int'(who_ch), 0);
        step();
        check("inc_count0", c0(), 1);
        check("inc_count1", c1(), 1);
        check("inc_winner0", int'(winner[0]), 0);
        check("inc_loser0", int'(loser[0]), 0);

        // Wrap
        set_ch(0, 1'b1, 4'd1, 2'b00);
        step();
        check("load1", c0(), 1);
        set_ch(0, 1'b0, 4'd0, 2'b11);
        step();
        check("dec2_a", c0(), 15);
        check("dec2_a_win", int'(winner[0]), 1);
        step();
        check("dec2_b", c0(), 13);
        check("dec2_b_win", int'(winner[0]), 0);
        set_ch(0, 1'b1, 4'd14, 2'b11);
        step();
        check("load14", c0(), 14);
        set_ch(0, 1'b0, 4'd0, 2'b00);
        step();
        check("inc_15", c0(), 15);
        check("inc_15_win", int'(winner[0]), 1);
        step();
        check("inc_wrap", c0(), 0);
        check("inc_wrap_lose", int'(loser[0]), 1);
        check("inc_wrap_win", int'(winner[0]), 0);

        // Win game on ch0, then back-to-back game
        do_reset();
        set_ch(0, 1'b1, 4'd15, 2'b00);
        set_ch(1, 1'b1, 4'd5, 2'b00);
        for (int n = 1; n <= 15; n++) begin
            step();
            check("win_hold_count", c0(), 15);
            check("win_hold_gameover", int'(gameover), 0);
        end
        step();
        check("win_gameover", int'(gameover), 1);
        check("win_who", int'(who), 1);
        check("win_who_ch", int'(who_ch), 0);
        step();
        check("win_over_gameover", int'(gameover), 0);
        check("win_over_who", int'(who), 0);
        for (int n = 18; n <= 31; n++) begin
            step();
            check("win2_wait_gameover", int'(gameover), 0);
        end
        step();
        check("win2_gameover", int'(gameover), 1);
        check("win2_who", int'(who), 1);

        // Simultaneous lose on both channels
        do_reset();
        set_ch(0, 1'b1, 4'd0, 2'b00);
        set_ch(1, 1'b1, 4'd0, 2'b00);
        for (int n = 1; n <= 15; n++) begin
            step();
            check("sim_wait_gameover", int'(gameover), 0);
        end
        step();
        check("sim_gameover", int'(gameover), 1);
        check("sim_who", int'(who), 2);
        check("sim_who_ch", int'(who_ch), 0);
        // ch0 stops hitting; ch1 keeps losing and must start its tally from scratch
        set_ch(0, 1'b1, 4'd5, 2'b00);
        step();
        check("sim_over_gameover", int'(gameover), 0);
        for (int n = 18; n <= 31; n++) begin
            step();
            check("sim_ch1_wait_gameover", int'(gameover), 0);
        end
        step();
        check("sim_ch1_gameover", int'(gameover), 1);
        check("sim_ch1_who", int'(who), 2);
        check("sim_ch1_who_ch", int'(who_ch), 1);

        // ch1 held at 15 through OVER
        do_reset();
        set_ch(0, 1'b1, 4'd5, 2'b00);
        set_ch(1, 1'b1, 4'd15, 2'b00);
        for (int n = 1; n <= 15; n++) begin
            step();
            check("ign_wait_gameover", int'(gameover), 0);
        end
        step();
        check("ign_gameover", int'(gameover), 1);
        check("ign_who", int'(who), 1);
        check("ign_who_ch", int'(who_ch), 1);
        step();
        check("ign_over_gameover", int'(gameover), 0);
        check("ign_over_winner1", int'(winner[1]), 1);
        for (int n = 18; n <= 31; n++) begin
            step();
            check("ign_wait2_gameover", int'(gameover), 0);
        end
        step();
        check("ign2_gameover", int'(gameover), 1);
        check("ign2_who_ch", int'(who_ch), 1);

        // Reset asserted during the gameover cycle
        do_reset();
        set_ch(0, 1'b1, 4'd15, 2'b00);
        set_ch(1, 1'b1, 4'd5, 2'b00);
        for (int n = 1; n <= 16; n++) step();
        check("mid_pre_gameover", int'(gameover), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_async_gameover", int'(gameover), 0);
        check("mid_async_who", int'(who), 0);
        check("mid_async_count", int'(count), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            step();
            check("mid_wait_gameover", int'(gameover), 0);
        end
        step();
        check("mid_gameover", int'(gameover), 1);
        check("mid_who", int'(who), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
